c17_pipe_array: RTL and testbench

- Multi-lane, pipelined, flow-controlled successor to the combinational c17 benchmark netlist.
- Evaluates LANES independent copies of the c17 function per transaction, over a 2-stage registered pipeline with valid/ready handshakes on both sides.
- Counts delivered results.
- Serves as a sequential benchmark/reference block for clocked FCN flows and as a golden model feeding equivalence benches.

---
 rtl/c17_pkg.sv | 33 +++
 rtl/c17_lane.sv | 31 +++
 rtl/c17_pipe_array.sv | 78 +++++++
 tb/tb_c17_pipe_array.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/c17_pkg.sv
// Shared definitions for the pipelined c17 array: lane widths, the stage-1
// intermediate struct, and the per-lane evaluation functions.
package c17_pkg;

    localparam int PI_PER_LANE = 5;
    localparam int PO_PER_LANE = 2;

    typedef struct packed {
        logic n9;
        logic n10;
        logic n12;
    } c17_s1_t;

    function automatic c17_s1_t c17_stage1_eval(input logic [PI_PER_LANE-1:0] pi);
        logic n8;
        c17_s1_t s1;
        n8     = pi[2] & pi[3];
        s1.n9  = pi[1] & ~n8;
        s1.n10 = pi[0] & pi[2];
        s1.n12 = pi[4] & ~n8;
        return s1;
    endfunction

    // Result packing: bit 0 = po0, bit 1 = po1.
    function automatic logic [PO_PER_LANE-1:0] c17_stage2_eval(input c17_s1_t s1);
        return {s1.n9 | s1.n12, s1.n9 | s1.n10};
    endfunction

    function automatic logic [PO_PER_LANE-1:0] c17_lane_eval(input logic [PI_PER_LANE-1:0] pi);
        return c17_stage2_eval(c17_stage1_eval(pi));
    endfunction

endpackage

// File: rtl/c17_lane.sv
// One c17 lane as a 2-stage registered datapath; load enables come from the
// shared handshake control in the top.
module c17_lane
    import c17_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s1_load,
    input  logic                   s2_load,
    input  logic [PI_PER_LANE-1:0] pi,
    output logic [PO_PER_LANE-1:0] po,
    output logic [PO_PER_LANE-1:0] po_next
);

    c17_s1_t s1_q;

    assign po_next = c17_stage2_eval(s1_q);

    // NOTE: data flops are reset too so a discarded transaction can never leave
    // a stale pattern on out_po after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            po   <= '0;
        end else begin
            if (s1_load) s1_q <= c17_stage1_eval(pi);
            if (s2_load) po   <= po_next;
        end
    end

endmodule

// File: rtl/c17_pipe_array.sv
// LANES-wide c17 evaluator behind a 2-stage valid/ready pipeline with a
// delivered-result counter. Define C17_PIPE_ARRAY_PARITY_EN to add out_par.
module c17_pipe_array
    import c17_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int COUNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PI_PER_LANE*LANES-1:0]   in_pi,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PO_PER_LANE*LANES-1:0]   out_po,
`ifdef C17_PIPE_ARRAY_PARITY_EN
    output logic                           out_par,
`endif
    output logic [COUNT_W-1:0]             out_count,
    output logic                           busy
);

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;
    logic in_xfer;
    logic [PO_PER_LANE*LANES-1:0] po_next;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign in_xfer   = in_valid && s1_adv;
    assign out_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_count <= '0;
        end else begin
            if (s1_adv) s1_valid <= in_xfer;
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_valid && out_ready) out_count <= out_count + COUNT_W'(1);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        c17_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .s1_load (in_xfer),
            .s2_load (s2_adv),
            .pi      (in_pi[k*PI_PER_LANE +: PI_PER_LANE]),
            .po      (out_po[k*PO_PER_LANE +: PO_PER_LANE]),
            .po_next (po_next[k*PO_PER_LANE +: PO_PER_LANE])
        );
    end

`ifdef C17_PIPE_ARRAY_PARITY_EN
    // Parity shares the stage-2 load enable, so it is held exactly like out_po.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (s2_adv) begin
            out_par <= ^po_next;
        end
    end
`else
    logic unused_po_next;
    assign unused_po_next = ^po_next;
`endif

endmodule

// File: tb/tb_c17_pipe_array.sv
// Self-checking bench for c17_pipe_array: queue-based reference model with a
// per-cycle compare process, plus directed latency/backpressure/reset/wrap cases.
module tb_c17_pipe_array;
    import c17_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_pi = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_po;
    logic [15:0] out_count;
    logic        busy;

    logic        w_valid = 1'b0;
    logic        w_in_ready;
    logic [4:0]  w_pi = '0;
    logic        w_out_valid;
    logic [1:0]  w_po;
    logic [2:0]  w_count;
    logic        w_busy;
`ifdef C17_PIPE_ARRAY_PARITY_EN
    logic        out_par;
    logic        w_par;
`endif

    always #5 clk = ~clk;

    c17_pipe_array #(.LANES(4), .COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pi(in_pi),
        .out_valid(out_valid), .out_ready(out_ready), .out_po(out_po),
`ifdef C17_PIPE_ARRAY_PARITY_EN
        .out_par(out_par),
`endif
        .out_count(out_count), .busy(busy)
    );

    c17_pipe_array #(.LANES(1), .COUNT_W(3)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_valid), .in_ready(w_in_ready), .in_pi(w_pi),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_po(w_po),
`ifdef C17_PIPE_ARRAY_PARITY_EN
        .out_par(w_par),
`endif
        .out_count(w_count), .busy(w_busy)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the c17 equations written straight from the lane definition.
    function automatic logic [1:0] lane_model(input logic [4:0] a);
        logic blk;
        blk = a[2] & a[3];
        return {(a[1] & ~blk) | (a[4] & ~blk), (a[1] & ~blk) | (a[0] & a[2])};
    endfunction

    function automatic logic [7:0] model(input logic [19:0] pi);
        logic [7:0] r;
        for (int k = 0; k < 4; k++) r[2*k +: 2] = lane_model(pi[5*k +: 5]);
        return r;
    endfunction

    typedef struct {
        logic [7:0] po;
        int         acc;
    } ent_t;

    ent_t        q[$];
    logic [15:0] mcount = '0;
    int          cyc = 0;

    // Per-cycle compare at the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_ready;
            logic exp_valid;
            cyc++;
            exp_ready = !(q.size() == 2 && !out_ready);
            exp_valid = q.size() != 0 && (cyc - q[0].acc) >= 2;
            check("in_ready", in_ready, exp_ready);
            check("busy", busy, q.size() != 0);
            check("out_valid", out_valid, exp_valid);
            check("out_count", out_count, mcount);
            if (exp_valid) begin
                check("out_po", out_po, q[0].po);
`ifdef C17_PIPE_ARRAY_PARITY_EN
                check("out_par", out_par, ^q[0].po);
`endif
            end
            if (exp_valid && out_ready) begin
                void'(q.pop_front());
                mcount++;
            end
            if (in_valid && exp_ready) q.push_back('{po: model(in_pi), acc: cyc});
        end
    end

    task automatic drive(input logic v, input logic [19:0] pi, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pi     = pi;
        out_ready = r;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_count", out_count, 16'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_po", out_po, 8'h00);
        q.delete();
        mcount = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready_held", in_ready, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) drive(1'b0, 20'h0, 1'b1);
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic [19:0] pi;
        int          acc;
        logic        hold;
        logic [2:0]  seq[$];
        logic [2:0]  prev;

        // Pin the reference model with hand-computed values.
        check("model_8144E", model(20'h8144E), 8'h9C);
        check("lane_02", lane_model(5'h02), 2'b11);
        check("lane_0E", lane_model(5'h0E), 2'b00);
        check("lane_10", lane_model(5'h10), 2'b10);
        for (int p = 0; p < 32; p++) check("pkg_eval", c17_lane_eval(5'(p)), lane_model(5'(p)));

        #3;
        do_reset();

        // Single transfer, literal latency and result.
        drive(1'b1, 20'h8144E, 1'b1);
        drive(1'b0, 20'h0, 1'b1);
        check("single_t1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("single_t2_valid", out_valid, 1'b1);
        check("single_po", out_po, 8'h9C);
        check("single_cnt0", out_count, 16'd0);
`ifdef C17_PIPE_ARRAY_PARITY_EN
        check("single_par", out_par, 1'b0);
`endif
        @(posedge clk); #1;
        check("single_cnt1", out_count, 16'd1);
        check("single_t3_valid", out_valid, 1'b0);

        // Exhaustive back-to-back sweep.
        do_reset();
        for (int p = 0; p < 32; p++) begin
            logic [4:0] l;
            l = 5'(p);
            drive(1'b1, {4{l}}, 1'b1);
            check("sweep_in_ready", in_ready, 1'b1);
        end
        drain();
        check("sweep_count", out_count, 16'd32);

        // Backpressure: two accepts then stall.
        acc = 0;
        pi  = $urandom;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pi, 1'b0);
            if (in_ready) begin
                acc++;
                pi = $urandom;
            end
        end
        check("bp_accepts", acc, 2);
        check("bp_in_ready", in_ready, 1'b0);
        drain();
        check("bp_count", out_count, 16'd34);

        // Reset with both stages full.
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0);
        #2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 20'h0, 1'b1);
            check("post_rst_no_stale", out_valid, 1'b0);
        end

        // Random traffic, upstream holds data while stalled.
        for (int i = 0; i < 10000; i++) begin
            hold = in_valid && !in_ready;
            if (hold) drive(1'b1, in_pi, 1'($urandom));
            else      drive(1'($urandom), $urandom, 1'($urandom));
        end
        drain();

        // Counter wrap on a 3-bit instance.
        do_reset();
        prev = '0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            w_valid = (i < 9);
            w_pi    = 5'($urandom);
            if (w_count != prev) begin
                seq.push_back(w_count);
                prev = w_count;
            end
        end
        check("wrap_deliveries", seq.size(), 9);
        if (seq.size() >= 3) begin
            check("wrap_seq_m3", seq[seq.size()-3], 3'd7);
            check("wrap_seq_m2", seq[seq.size()-2], 3'd0);
            check("wrap_seq_m1", seq[seq.size()-1], 3'd1);
        end
        check("wrap_idle", w_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
